// File: rtl/mem_responder_pkg.sv
// ------------------------------------------------------------------
// mem_responder_pkg : bus types and request record for mem_responder
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_type;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_type;

  localparam mem_req_type c_mem_req_zero = '0;

endpackage

`default_nettype wire

// File: rtl/mem_ram_array.sv
// ------------------------------------------------------------------
// mem_ram_array : single-port 32-bit RAM, byte write enables, registered read
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_ram_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // Read-before-write: a write cycle returns the old word, which the
  // responder discards anyway.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ------------------------------------------------------------------
// mem_responder : on-chip RAM endpoint with programmable wait states
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready
);

  localparam logic [3:0] c_wait = 4'(WAIT_STATES);

  mem_resp_state_type state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  mem_req_type        req_q, req_d;
  logic               ready_q, ready_d;
  logic               zero_q, zero_d;

  mem_req_type             acc_req;
  logic                    acc_en;
  logic [31:0]             acc_off;
  logic                    acc_in_win;
  logic                    acc_write;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    acc_en  = 1'b0;
    acc_req = req_q;
    case (state_q)
      IDLE: begin
        if (memory_valid) begin
          req_d = '{instr: memory_instr, addr: memory_addr,
                    wdata: memory_wdata, wstrb: memory_wstrb};
          cnt_d = c_wait;
          if (c_wait == 4'd0) begin
            // Zero wait states: the access uses the live request.
            state_d = RESP;
            acc_en  = 1'b1;
            acc_req = req_d;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Window decode on the offset from BASE_ADDR; addr[1:0] is ignored.
  always_comb begin
    acc_off    = acc_req.addr - BASE_ADDR;
    acc_in_win = (acc_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    acc_idx    = acc_off[DEPTH_LOG2+1:2];
    acc_write  = acc_in_win && (acc_req.wstrb != 4'd0) && !acc_req.instr;
    ready_d    = acc_en;
    zero_d     = acc_en ? (!acc_in_win || acc_write) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= c_mem_req_zero;
      ready_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      zero_q  <= zero_d;
    end
  end

  mem_ram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (acc_en && rst),
    .we    ((acc_write && rst) ? acc_req.wstrb : 4'd0),
    .addr  (acc_idx),
    .wdata (acc_req.wdata),
    .rdata (ram_rdata)
  );

  assign memory_ready = ready_q;
  assign memory_rdata = (ready_q && !zero_q) ? ram_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ------------------------------------------------------------------
// tb_mem_responder : directed checks on three responders (WAIT_STATES 1, 0, 4)
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        v   [3];
  logic        ins [3];
  logic [31:0] ad  [3];
  logic [31:0] wd  [3];
  logic [3:0]  st  [3];
  logic [31:0] rd  [3];
  logic        rdy [3];

  int checks   = 0;
  int failures = 0;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 4;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_responder #(
      .DEPTH_LOG2  (12),
      .WAIT_STATES ((k == 0) ? 1 : (k == 1) ? 0 : 4),
      .BASE_ADDR   (32'h0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .memory_valid (v[k]),
      .memory_instr (ins[k]),
      .memory_addr  (ad[k]),
      .memory_wdata (wd[k]),
      .memory_wstrb (st[k]),
      .memory_rdata (rd[k]),
      .memory_ready (rdy[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request: capture, wait for ready, check latency/rdata and that
  // ready drops the following cycle. Leaves the DUT in IDLE.
  task automatic xact(input int k, input logic i_ins, input logic [31:0] i_ad,
                      input logic [31:0] i_wd, input logic [3:0] i_st,
                      input logic [31:0] exp_rd, input string tag);
    int          lat;
    logic [31:0] got;
    lat = 0;
    got = '0;
    @(negedge clk);
    v[k] = 1'b1; ins[k] = i_ins; ad[k] = i_ad; wd[k] = i_wd; st[k] = i_st;
    @(posedge clk);
    #1;
    v[k] = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (rdy[k]) begin
        lat = j + 1;
        got = rd[k];
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_lat"}, lat, ws_of(k) + 1);
    check({tag, "_rdata"}, got, exp_rd);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, rdy[k]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; ins[k] = 1'b0; ad[k] = '0; wd[k] = '0; st[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_ready", {31'd0, rdy[k]}, 32'd0);
      check("reset_rdata", rd[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // WAIT_STATES=1: full write then read back
    xact(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        "ws1_write");
    xact(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, "ws1_read");

    // Byte strobe on lane 0, misaligned read address
    xact(0, 1'b0, 32'h10, 32'h00000055, 4'h1, 32'h0,        "strb_write");
    xact(0, 1'b0, 32'h13, 32'h0,        4'h0, 32'hDEADBE55, "strb_read");

    // Out-of-window write must not alias onto word 0
    xact(0, 1'b0, 32'h0,    32'hA5A5A5A5, 4'hF, 32'h0,        "w0_write");
    xact(0, 1'b0, 32'h4000, 32'h12345678, 4'hF, 32'h0,        "oow_write");
    xact(0, 1'b0, 32'h4000, 32'h0,        4'h0, 32'h0,        "oow_read");
    xact(0, 1'b0, 32'h0,    32'h0,        4'h0, 32'hA5A5A5A5, "w0_read");

    // Instruction fetch with strobes is a read
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 32'hDEADBE55, "ifetch");
    xact(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBE55, "ifetch_after");

    // WAIT_STATES=0 with valid held high: ready alternates
    xact(1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "ws0_write");
    @(negedge clk);
    v[1] = 1'b1; ins[1] = 1'b0; ad[1] = 32'h10; wd[1] = 32'h0; st[1] = 4'h0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      check("ws0_hold_ready", {31'd0, rdy[1]}, (j % 2 == 0) ? 32'd1 : 32'd0);
      check("ws0_hold_rdata", rd[1], (j % 2 == 0) ? 32'hDEADBEEF : 32'h0);
    end
    @(negedge clk);
    v[1] = 1'b0;
    repeat (2) @(posedge clk);

    // WAIT_STATES=4: reset during WAIT drops the request
    xact(2, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, "ws4_write");
    @(negedge clk);
    v[2] = 1'b1; ins[2] = 1'b0; ad[2] = 32'h20; wd[2] = 32'h0; st[2] = 4'h0;
    @(posedge clk);
    #1;
    v[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ready", {31'd0, rdy[2]}, 32'd0);
    check("rst_mid_rdata", rd[2], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (rdy[2]) seen = 1;
    end
    check("rst_no_ready", seen, 32'd0);
    xact(2, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, "ws4_read_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
